// File: rtl/cordic_pkg.sv
// rtl/cordic_pkg.sv - shared CORDIC constants, atan table and FSM state encoding
//
// Used by the vectoring-mode CORDIC (cordic_vector) and the rotation-mode CORDIC.
// All angles are signed Q3.16 radians; all coordinates carry 16 fraction bits.
package cordic_pkg;

    localparam int BIT_SIZE_DEF = 18;
    localparam int FRAC_BITS    = 16;
    localparam int ANGLE_W      = 19;
    localparam int ATAN_ENTRIES = 18;

    // 1/(CORDIC gain) = 0.607254 in Q2.16
    localparam logic [17:0]               K    = 18'h09B74;
    // pi/2 in Q3.16
    localparam logic signed [ANGLE_W-1:0] PI_2 = 19'sh19220;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PRE   = 3'd1,
        ITER  = 3'd2,
        SCALE = 3'd3,
        DONE  = 3'd4
    } cordic_state_e;

    // atan(2^-idx) in Q3.16; iterations past the table contribute no angle.
    function automatic logic signed [ANGLE_W-1:0] atan_lut(input int idx);
        logic signed [ANGLE_W-1:0] r;
        case (idx)
            0:       r = 19'sh0C90F;
            1:       r = 19'sh076B1;
            2:       r = 19'sh03EB6;
            3:       r = 19'sh01FD5;
            4:       r = 19'sh00FFA;
            5:       r = 19'sh007FF;
            6:       r = 19'sh003FF;
            7:       r = 19'sh001FF;
            8:       r = 19'sh000FF;
            9:       r = 19'sh0007F;
            10:      r = 19'sh0003F;
            11:      r = 19'sh0001F;
            12:      r = 19'sh0000F;
            13:      r = 19'sh00007;
            14:      r = 19'sh00003;
            15:      r = 19'sh00001;
            default: r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/cordic_vec_stage.sv
// rtl/cordic_vec_stage.sv - combinational single vectoring-mode CORDIC micro-rotation
//
// Ports:
//   x_i, y_i  current vector (signed, XW bits)
//   z_i       accumulated angle (signed Q3.16)
//   i_i       iteration index (shift amount and atan table index)
//   x_o, y_o  rotated vector, driven toward the +x axis
//   z_o       updated angle
module cordic_vec_stage
    import cordic_pkg::*;
#(
    parameter int XW = 20,
    parameter int CW = 5
) (
    input  logic signed [XW-1:0]      x_i,
    input  logic signed [XW-1:0]      y_i,
    input  logic signed [ANGLE_W-1:0] z_i,
    input  logic        [CW-1:0]      i_i,
    output logic signed [XW-1:0]      x_o,
    output logic signed [XW-1:0]      y_o,
    output logic signed [ANGLE_W-1:0] z_o
);

    logic signed [XW-1:0]      x_sh;
    logic signed [XW-1:0]      y_sh;
    logic signed [ANGLE_W-1:0] atan_i;

    // All three updates use the pre-iteration values of x, y and z.
    always_comb begin
        x_sh   = x_i >>> i_i;
        y_sh   = y_i >>> i_i;
        atan_i = atan_lut(int'(i_i));
        if (!y_i[XW-1]) begin
            x_o = x_i + y_sh;
            y_o = y_i - x_sh;
            z_o = z_i + atan_i;
        end else begin
            x_o = x_i - y_sh;
            y_o = y_i + x_sh;
            z_o = z_i - atan_i;
        end
    end

endmodule

// File: rtl/cordic_vector.sv
// rtl/cordic_vector.sv - iterative vectoring CORDIC: (x, y) -> magnitude, atan2(y, x)
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   init             start request (accepted in IDLE, or in DONE once done is high)
//   x_in, y_in       signed Q2.16 coordinates
//   magnitude        unsigned Q2.16 gain-compensated vector length
//   angle            signed Q3.16 atan2(y, x) in radians
//   busy             conversion in progress
//   done             magnitude/angle valid, held until the next accepted init
module cordic_vector
    import cordic_pkg::*;
#(
    parameter int ITERATIONS = 18,
    parameter int BIT_SIZE   = BIT_SIZE_DEF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      init,
    input  logic signed [BIT_SIZE-1:0] x_in,
    input  logic signed [BIT_SIZE-1:0] y_in,
    output logic        [BIT_SIZE-1:0] magnitude,
    output logic signed [ANGLE_W-1:0]  angle,
    output logic                      busy,
    output logic                      done
);

    // Two guard bits: room for negating -2 and for the ~1.65x CORDIC gain.
    localparam int XW = BIT_SIZE + 2;
    localparam int CW = (ITERATIONS > 1) ? $clog2(ITERATIONS) : 1;
    localparam int PW = XW + 19;

    cordic_state_e state_q, state_d;

    logic        [CW-1:0]       cnt_q;
    logic signed [XW-1:0]       x_q, y_q;
    logic signed [ANGLE_W-1:0]  z_q;
    logic        [BIT_SIZE-1:0] mag_q;
    logic signed [ANGLE_W-1:0]  ang_q;
    logic                       done_q;

    logic signed [XW-1:0]       x_n, y_n;
    logic signed [ANGLE_W-1:0]  z_n;
    logic                       accept;
    logic                       is_zero;
    logic signed [PW-1:0]       prod;
    logic signed [PW-1:0]       prod_sh;
    logic        [BIT_SIZE-1:0] mag_sat;

    cordic_vec_stage #(
        .XW (XW),
        .CW (CW)
    ) u_stage (
        .x_i (x_q),
        .y_i (y_q),
        .z_i (z_q),
        .i_i (cnt_q),
        .x_o (x_n),
        .y_o (y_n),
        .z_o (z_n)
    );

    assign is_zero = (x_q == '0) && (y_q == '0);

    // Gain compensation: Q4.16 * Q2.16 -> drop 16 fraction bits, clamp to unsigned range.
    always_comb begin
        prod    = x_q * $signed({1'b0, K});
        prod_sh = prod >>> FRAC_BITS;
        if (prod_sh[PW-1]) begin
            mag_sat = '0;
        end else if (|prod_sh[PW-1:BIT_SIZE]) begin
            mag_sat = '1;
        end else begin
            mag_sat = prod_sh[BIT_SIZE-1:0];
        end
    end

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = PRE;
            PRE:     state_d = is_zero ? SCALE : ITER;
            ITER:    if (cnt_q == CW'(ITERATIONS - 1)) state_d = SCALE;
            SCALE:   state_d = DONE;
            DONE:    if (accept) state_d = PRE;
            default: state_d = IDLE;
        endcase
    end

    // FSM: outputs. The first DONE cycle latches the result, so init there is
    // ignored (it coincides with done rising) and busy is still reported.
    always_comb begin
        accept = 1'b0;
        busy   = 1'b0;
        case (state_q)
            IDLE:    accept = init;
            PRE,
            ITER,
            SCALE:   busy = 1'b1;
            DONE: begin
                accept = init && done_q;
                busy   = !done_q;
            end
            default: ;
        endcase
    end

    // Datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            x_q    <= '0;
            y_q    <= '0;
            z_q    <= '0;
            mag_q  <= '0;
            ang_q  <= '0;
            done_q <= 1'b0;
        end else if (accept) begin
            x_q    <= {{(XW - BIT_SIZE){x_in[BIT_SIZE-1]}}, x_in};
            y_q    <= {{(XW - BIT_SIZE){y_in[BIT_SIZE-1]}}, y_in};
            z_q    <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            case (state_q)
                PRE: begin
                    cnt_q <= '0;
                    // Fold left half-plane into the right half-plane so the
                    // iterations only need to cover +-pi/2.
                    if (is_zero) begin
                        x_q <= '0;
                        z_q <= '0;
                    end else if (x_q[XW-1] && !y_q[XW-1]) begin
                        x_q <= y_q;
                        y_q <= -x_q;
                        z_q <= PI_2;
                    end else if (x_q[XW-1]) begin
                        x_q <= -y_q;
                        y_q <= x_q;
                        z_q <= -PI_2;
                    end
                end
                ITER: begin
                    x_q   <= x_n;
                    y_q   <= y_n;
                    z_q   <= z_n;
                    cnt_q <= cnt_q + CW'(1);
                end
                SCALE: begin
                    x_q <= {{(XW - BIT_SIZE){1'b0}}, mag_sat};
                end
                DONE: begin
                    if (!done_q) begin
                        mag_q  <= x_q[BIT_SIZE-1:0];
                        ang_q  <= z_q;
                        done_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign magnitude = mag_q;
    assign angle     = ang_q;
    assign done      = done_q;

endmodule

// File: tb/tb_cordic_vector.sv
// tb/tb_cordic_vector.sv - self-checking bench for cordic_vector
module tb_cordic_vector;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               init;
    logic signed [17:0] x_in;
    logic signed [17:0] y_in;
    logic        [17:0] magnitude;
    logic signed [18:0] angle;
    logic               busy;
    logic               done;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int    mag;
        int    ang;
        int    mtol;
        int    atol;
        bit    ang_pm;
        int    lat;
        string tag;
    } exp_t;

    exp_t sb[$];

    cordic_vector #(
        .ITERATIONS (18),
        .BIT_SIZE   (18)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .init      (init),
        .x_in      (x_in),
        .y_in      (y_in),
        .magnitude (magnitude),
        .angle     (angle),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int expv, input int tol);
        int d;
        d = obs - expv;
        if (d < 0) d = -d;
        checks++;
        assert (d <= tol) else begin
            errors++;
            $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h) tol %0d",
                   tag, obs, obs, expv, expv, tol);
        end
    endtask

    // Starts one conversion, optionally re-pulsing init so it is sampled on
    // edge 'repulse' after the start edge, and checks the scoreboard result.
    task automatic convert(input logic signed [17:0] x, input logic signed [17:0] y,
                           input int mag, input int ang, input int mtol, input int atol,
                           input bit pm, input int lat, input int repulse, input string tag);
        exp_t e;
        int   c;
        int   a;
        e.mag = mag; e.ang = ang; e.mtol = mtol; e.atol = atol;
        e.ang_pm = pm; e.lat = lat; e.tag = tag;
        sb.push_back(e);
        x_in = x;
        y_in = y;
        init = 1'b1;
        @(posedge clk); #1;
        init = 1'b0;
        // different data on the bus so a wrongly accepted restart shows up
        x_in = ~x;
        y_in = ~y;
        check({tag, "_busy_start"}, int'(busy), 1, 0);
        check({tag, "_done_clr"}, int'(done), 0, 0);
        c = 0;
        while (done !== 1'b1 && c < 40) begin
            init = (c + 1 == repulse);
            @(posedge clk); #1;
            c++;
        end
        init = 1'b0;
        check({tag, "_done_seen"}, int'(done), 1, 0);
        e = sb.pop_front();
        if (e.lat > 0) check({e.tag, "_latency"}, c, e.lat, 0);
        check({e.tag, "_mag"}, int'(magnitude), e.mag, e.mtol);
        a = int'(angle);
        check({e.tag, "_ang"}, a, (e.ang_pm && a < 0) ? -e.ang : e.ang, e.atol);
        check({e.tag, "_busy_end"}, int'(busy), 0, 0);
        @(posedge clk); #1;
        check({e.tag, "_done_hold"}, int'(done), 1, 0);
        check({e.tag, "_busy_hold"}, int'(busy), 0, 0);
        check({e.tag, "_mag_hold"}, int'(magnitude), e.mag, e.mtol);
    endtask

    initial begin
        int   saw;
        exp_t e;
        rst_n = 1'b0;
        init  = 1'b0;
        x_in  = '0;
        y_in  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_mag", int'(magnitude), 0, 0);
        check("reset_ang", int'(angle), 0, 0);
        check("reset_busy", int'(busy), 0, 0);
        check("reset_done", int'(done), 0, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        convert(18'sh10000, 18'sh00000, 'h10000, 0, 8, 8, 1'b0, 21, 0, "x1_y0");
        convert(18'sh10000, 18'sh10000, 'h16A0A, 'h0C910, 8, 8, 1'b0, 21, 0, "x1_y1");
        convert(18'sh00000, 18'sh10000, 'h10000, 'h19220, 8, 8, 1'b0, 21, 0, "x0_y1");
        convert(-18'sh10000, 18'sh00000, 'h10000, 'h3243F, 8, 8, 1'b1, 21, 0, "xm1_y0");
        convert(18'sh00000, -18'sh10000, 'h10000, -'h19220, 8, 8, 1'b0, 21, 0, "x0_ym1");
        convert(18'sh00000, 18'sh00000, 0, 0, 0, 0, 1'b0, -1, 0, "zero");
        convert(18'sh20000, 18'sh20000, 'h2D414, -'h25B2F, 8, 8, 1'b0, 21, 0, "xm2_ym2");

        // init during the conversion is ignored
        convert(18'sh10000, 18'sh10000, 'h16A0A, 'h0C910, 8, 8, 1'b0, 21, 5, "repulse5");
        // init on the edge where done rises is ignored
        convert(18'sh10000, 18'sh00000, 'h10000, 0, 8, 8, 1'b0, 21, 21, "repulse_done");

        // reset in the middle of a conversion
        e.mag = 'h16A0A; e.ang = 'h0C910; e.mtol = 8; e.atol = 8;
        e.ang_pm = 1'b0; e.lat = 21; e.tag = "aborted";
        sb.push_back(e);
        x_in = 18'sh10000;
        y_in = 18'sh10000;
        init = 1'b1;
        @(posedge clk); #1;
        init = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_mag", int'(magnitude), 0, 0);
        check("abort_ang", int'(angle), 0, 0);
        check("abort_busy", int'(busy), 0, 0);
        check("abort_done", int'(done), 0, 0);
        sb.delete();
        check("abort_sb_empty", sb.size(), 0, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        saw = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done === 1'b1 || busy === 1'b1) saw++;
        end
        check("abort_no_done", saw, 0, 0);

        convert(18'sh00000, 18'sh10000, 'h10000, 'h19220, 8, 8, 1'b0, 21, 0, "after_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
